memctrl_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter and access sequencer in front of the memory controller's single host port (ADDR/CE/CSB/WEB/OEB/IDATA/ODATA).
- Shares that port between a primary host requester (port 0) and a secondary requester (port 1, e.g. DMA or scrubber).
- Turns each requester's request/grant handshake into correctly timed active-low memory strobes and returns read data with a valid pulse.
- Holds off all new grants while BIST_EN is asserted, so self-test and repair own the array undisturbed.

---
 rtl/memctrl_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_memctrl_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memctrl_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing the memory controller host port between two requesters.
// Latency: GNT one cycle after REQ is seen in IDLE; strobes the cycle after GNT; RVALID RD_LAT+2 cycles after GNT.
// Backpressure: REQn is held until GNTn; one access in flight; BIST_EN blocks new grants but lets the current access finish.
//
// Ports:
//   CLK, RSTN                       clock, async active-low reset
//   REQn/WEn/ADDRn/WDATAn (n=0,1)   request side; WE/ADDR/WDATA sampled in the grant decision only
//   GNTn, RVALIDn, RDATA            one-cycle grant pulse, one-cycle read-valid pulse, shared read data
//   BIST_EN, BUSY                   grant inhibit, sequencer activity
//   ADDR/CE/CSB/WEB/OEB/IDATA/ODATA memory controller host port (strobes active low except CE)
module memctrl_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1   // 1..7
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  output logic          GNT0,
  output logic          RVALID0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic [DW-1:0] RDATA,
  input  logic          BIST_EN,
  output logic          BUSY,
  output logic [AW-1:0] ADDR,
  output logic          CE,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic [DW-1:0] IDATA,
  input  logic [DW-1:0] ODATA
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RDWAIT} state_t;

  localparam logic [2:0] LP_RD_LAT = 3'(RD_LAT);

  state_t        r_state, w_state_nxt;

  // Latched command and arbitration history
  logic          r_lat_we,    w_lat_we_nxt;
  logic [AW-1:0] r_lat_addr,  w_lat_addr_nxt;
  logic [DW-1:0] r_lat_wdata, w_lat_wdata_nxt;
  logic          r_owner,     w_owner_nxt;
  logic          r_last,      w_last_nxt;
  logic [2:0]    r_cnt,       w_cnt_nxt;

  // Registered outputs
  logic          r_gnt0,   w_gnt0_nxt;
  logic          r_gnt1,   w_gnt1_nxt;
  logic          r_rvld0,  w_rvld0_nxt;
  logic          r_rvld1,  w_rvld1_nxt;
  logic [DW-1:0] r_rdata,  w_rdata_nxt;
  logic          r_busy,   w_busy_nxt;
  logic [AW-1:0] r_addr,   w_addr_nxt;
  logic          r_ce,     w_ce_nxt;
  logic          r_csb,    w_csb_nxt;
  logic          r_web,    w_web_nxt;
  logic          r_oeb,    w_oeb_nxt;
  logic [DW-1:0] r_idata,  w_idata_nxt;

  // On a tie the port that did not win last time gets the grant.
  logic w_win;
  assign w_win = (REQ0 && REQ1) ? ~r_last : REQ1;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Strobe outputs are registered from the next-cycle view, so the strobes
  // for CMD appear the cycle after the grant pulse. The RDWAIT counter is
  // loaded with RD_LAT as the command cycle starts and reaches 0 exactly in
  // the cycle ODATA is valid, which is when it is captured.
  always_comb begin
    w_state_nxt     = r_state;
    w_lat_we_nxt    = r_lat_we;
    w_lat_addr_nxt  = r_lat_addr;
    w_lat_wdata_nxt = r_lat_wdata;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_gnt0_nxt      = 1'b0;
    w_gnt1_nxt      = 1'b0;
    w_rvld0_nxt     = 1'b0;
    w_rvld1_nxt     = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_addr_nxt      = r_addr;
    w_idata_nxt     = r_idata;
    w_ce_nxt        = 1'b0;
    w_csb_nxt       = 1'b1;
    w_web_nxt       = 1'b1;
    w_oeb_nxt       = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!BIST_EN && (REQ0 || REQ1)) begin
          w_lat_we_nxt    = w_win ? WE1    : WE0;
          w_lat_addr_nxt  = w_win ? ADDR1  : ADDR0;
          w_lat_wdata_nxt = w_win ? WDATA1 : WDATA0;
          w_owner_nxt     = w_win;
          w_last_nxt      = w_win;
          w_gnt0_nxt      = ~w_win;
          w_gnt1_nxt      = w_win;
          w_state_nxt     = ST_CMD;
        end
      end
      ST_CMD: begin
        w_csb_nxt  = 1'b0;
        w_ce_nxt   = 1'b1;
        w_addr_nxt = r_lat_addr;
        if (r_lat_we) begin
          w_web_nxt   = 1'b0;
          w_idata_nxt = r_lat_wdata;
          w_state_nxt = ST_IDLE;
        end else begin
          w_oeb_nxt   = 1'b0;
          w_cnt_nxt   = LP_RD_LAT;
          w_state_nxt = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        if (r_cnt == 3'd0) begin
          // Strobes fall back to their inactive defaults next cycle.
          w_rdata_nxt = ODATA;
          w_rvld0_nxt = ~r_owner;
          w_rvld1_nxt = r_owner;
          w_state_nxt = ST_IDLE;
        end else begin
          w_csb_nxt = 1'b0;
          w_ce_nxt  = 1'b1;
          w_oeb_nxt = 1'b0;
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Busy also covers the write strobe cycle, when the FSM is already back in IDLE.
    w_busy_nxt = (w_state_nxt != ST_IDLE) || !w_csb_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_lat_we    <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_cnt       <= 3'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvld0     <= 1'b0;
      r_rvld1     <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_addr      <= '0;
      r_ce        <= 1'b0;
      r_csb       <= 1'b1;
      r_web       <= 1'b1;
      r_oeb       <= 1'b1;
      r_idata     <= '0;
    end else begin
      r_lat_we    <= w_lat_we_nxt;
      r_lat_addr  <= w_lat_addr_nxt;
      r_lat_wdata <= w_lat_wdata_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_rvld0     <= w_rvld0_nxt;
      r_rvld1     <= w_rvld1_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_addr      <= w_addr_nxt;
      r_ce        <= w_ce_nxt;
      r_csb       <= w_csb_nxt;
      r_web       <= w_web_nxt;
      r_oeb       <= w_oeb_nxt;
      r_idata     <= w_idata_nxt;
    end
  end

  assign GNT0    = r_gnt0;
  assign GNT1    = r_gnt1;
  assign RVALID0 = r_rvld0;
  assign RVALID1 = r_rvld1;
  assign RDATA   = r_rdata;
  assign BUSY    = r_busy;
  assign ADDR    = r_addr;
  assign CE      = r_ce;
  assign CSB     = r_csb;
  assign WEB     = r_web;
  assign OEB     = r_oeb;
  assign IDATA   = r_idata;

endmodule

// File: tb/tb_memctrl_port_arbiter.sv
// Directed bench for memctrl_port_arbiter with a latency-accurate memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_memctrl_port_arbiter;

  localparam int RD_LAT = 3;

  logic        CLK, RSTN;
  logic        REQ0, WE0, REQ1, WE1, BIST_EN;
  logic [15:0] ADDR0, ADDR1;
  logic [7:0]  WDATA0, WDATA1;
  logic        GNT0, GNT1, RVALID0, RVALID1, BUSY, CE, CSB, WEB, OEB;
  logic [7:0]  RDATA, IDATA, ODATA;
  logic [15:0] ADDR;

  int n_vec = 0;
  int n_err = 0;

  memctrl_port_arbiter #(.AW(16), .DW(8), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .GNT0(GNT0), .RVALID0(RVALID0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .GNT1(GNT1), .RVALID1(RVALID1),
    .RDATA(RDATA), .BIST_EN(BIST_EN), .BUSY(BUSY),
    .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB), .IDATA(IDATA), .ODATA(ODATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Memory: writes land in the strobe cycle; read data is valid only in the
  // cycle RD_LAT after the first cycle of a read command.
  logic [7:0] mem [0:65535];
  bit         in_read;
  int         rem;
  logic [7:0] rd_val;

  initial begin
    in_read = 0;
    rem     = 0;
    rd_val  = 8'h00;
    ODATA   = 8'hEE;
    mem[16'hFFFF] = 8'h3C;
    forever begin
      @(negedge CLK);
      if (!CSB && !WEB) mem[ADDR] = IDATA;
      if (CSB) in_read = 0;
      else if (!OEB && !in_read) begin
        in_read = 1;
        rem     = RD_LAT;
        rd_val  = mem[ADDR];
      end else if (in_read) rem--;
      ODATA = (in_read && rem == 0) ? rd_val : 8'hEE;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_gnt(input int port, input string tag);
    int n;
    n = 0;
    while (n < 20) begin
      tick();
      if ((port == 0 && GNT0) || (port == 1 && GNT1)) break;
      n++;
    end
    check(tag, int'(n < 20), 1);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
  endtask

  task automatic run_read(input int port, input logic [15:0] addr, input logic [7:0] exp, input string tag);
    int oeb_lo, web_lo, rv_cyc, rv_extra, rv_other;
    logic [7:0] got;
    oeb_lo = 0; web_lo = 0; rv_cyc = -1; rv_extra = 0; rv_other = 0; got = 8'h00;
    if (port == 0) begin REQ0 = 1; WE0 = 0; ADDR0 = addr; end
    else           begin REQ1 = 1; WE1 = 0; ADDR1 = addr; end
    wait_gnt(port, {tag, "_gnt"});
    REQ0 = 0; REQ1 = 0;
    for (int k = 1; k <= RD_LAT + 5; k++) begin
      tick();
      if (!OEB) oeb_lo++;
      if (!WEB) web_lo++;
      if ((port == 0) ? RVALID0 : RVALID1) begin
        if (rv_cyc < 0) begin rv_cyc = k; got = RDATA; end
        else rv_extra++;
      end
      if ((port == 0) ? RVALID1 : RVALID0) rv_other++;
    end
    check({tag, "_rv_lat"},   rv_cyc,   RD_LAT + 2);
    check({tag, "_rdata"},    int'(got), int'(exp));
    check({tag, "_oeb_lo"},   oeb_lo,   RD_LAT + 1);
    check({tag, "_web_lo"},   web_lo,   0);
    check({tag, "_rv_extra"}, rv_extra, 0);
    check({tag, "_rv_other"}, rv_other, 0);
  endtask

  initial begin
    int seq [4];
    int gcyc [4];
    int ng, both, long_pulse, g1, rv, bad;
    bit prev;
    logic [7:0] rd;

    RSTN = 0; REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; BIST_EN = 0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;

    // Reset values
    repeat (2) tick();
    check("rst_ctl", int'({CSB, CE, WEB, OEB, BUSY, GNT0, GNT1, RVALID0, RVALID1}), 'b101100000);
    check("rst_addr",  int'(ADDR),  0);
    check("rst_idata", int'(IDATA), 0);
    check("rst_rdata", int'(RDATA), 0);
    RSTN = 1;
    tick();

    // Single write from port 0
    REQ0 = 1; WE0 = 1; ADDR0 = 16'h1234; WDATA0 = 8'hA5;
    wait_gnt(0, "wr_gnt0");
    check("wr_gnt_cycle", int'({GNT1, CSB}), 'b01);
    REQ0 = 0;
    tick();
    check("wr_strobes", int'({CSB, CE, WEB, OEB, GNT0}), 'b01010);
    check("wr_addr",    int'(ADDR),  16'h1234);
    check("wr_idata",   int'(IDATA), 8'hA5);
    tick();
    check("wr_restore", int'({CSB, CE, WEB, OEB}), 'b1011);

    // Read back from port 0
    run_read(0, 16'h1234, 8'hA5, "rd0");

    // Both ports requesting continuously from reset
    do_reset();
    REQ0 = 1; WE0 = 1; ADDR0 = 16'h0010; WDATA0 = 8'h11;
    REQ1 = 1; WE1 = 1; ADDR1 = 16'h0020; WDATA1 = 8'h22;
    ng = 0; both = 0; long_pulse = 0; prev = 0;
    for (int c = 1; c <= 16 && ng < 4; c++) begin
      tick();
      if (GNT0 && GNT1) both++;
      if (GNT0 || GNT1) begin
        if (prev) long_pulse++;
        seq[ng]  = int'(GNT1);
        gcyc[ng] = c;
        ng++;
      end
      prev = GNT0 || GNT1;
    end
    REQ0 = 0; REQ1 = 0;
    tick();
    if (GNT0 || GNT1) long_pulse++;
    check("rr_count", ng, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), seq[i], i % 2);
    check("rr_spacing", gcyc[3] - gcyc[0], 6);
    check("rr_both", both, 0);
    check("rr_pulse", long_pulse, 0);
    tick();

    // Port 1 alone reads the top address
    run_read(1, 16'hFFFF, 8'h3C, "rd1");

    // BIST raised right after a port 0 read grant
    REQ0 = 1; WE0 = 0; ADDR0 = 16'h1234;
    wait_gnt(0, "bist_gnt0");
    REQ0 = 0; BIST_EN = 1;
    REQ1 = 1; WE1 = 1; ADDR1 = 16'h0042; WDATA1 = 8'h77;
    g1 = 0; rv = -1; rd = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (RVALID0 && rv < 0) begin rv = k; rd = RDATA; end
      if (GNT1) g1++;
    end
    check("bist_rv_lat", rv, RD_LAT + 2);
    check("bist_rdata", int'(rd), 8'hA5);
    check("bist_no_gnt1", g1, 0);
    BIST_EN = 0;
    tick();
    check("bist_gnt1_after", int'(GNT1), 1);
    REQ1 = 0;
    tick();
    check("bist_wr_strobes", int'({CSB, WEB}), 'b00);
    check("bist_wr_addr", int'(ADDR), 16'h0042);
    tick();

    // Reset while a read is waiting
    REQ1 = 1; WE1 = 0; ADDR1 = 16'hFFFF;
    wait_gnt(1, "arst_gnt1");
    REQ1 = 0;
    repeat (2) tick();
    check("arst_in_read", int'(OEB), 0);
    #2 RSTN = 0;
    #1;
    check("arst_ctl", int'({CSB, CE, WEB, OEB, BUSY, GNT0, GNT1, RVALID0, RVALID1}), 'b101100000);
    check("arst_addr",  int'(ADDR),  0);
    check("arst_rdata", int'(RDATA), 0);
    tick();
    RSTN = 1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (RVALID0 || RVALID1 || BUSY) bad++;
    end
    check("arst_no_rvalid", bad, 0);

    // Idle window
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ({CSB, CE, WEB, OEB, BUSY} !== 5'b10110) bad++;
    end
    check("idle_strobes", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
